// File: rtl/quiz_bus_reader.sv
// quiz_bus_reader: read master for the RD side of the quizif bus.
// Client read requests are queued in a small FIFO. Each request is issued as
// one strobed bus read, and the returned byte goes back on a valid/ready port.
// Optional feature macro: QUIZ_RD_TIMEOUT_EN. It builds the STROBE timeout
// counter and the rsp_err path. When the macro is not defined, STROBE waits
// for da indefinitely and rsp_err is tied low.
module quiz_bus_reader #(
    parameter int DEPTH      = 4,
    parameter int TMO_CYCLES = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_addr,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [7:0] addr,
    output logic       as,
    output logic       rw,
    output logic       ds,
    input  logic       da,
    input  logic [7:0] data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        STROBE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t           state;
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;
    logic             push;
    logic             pop;
    logic             empty;

    assign empty = (count == '0);
    assign push  = req_valid && req_ready;
    // A new bus cycle starts only from IDLE, with data queued and the response slot free
    assign pop   = (state == IDLE) && !empty && !rsp_valid;

`ifdef QUIZ_RD_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);
    logic [7:0] tmo_cnt;
    logic       err_q;
    assign rsp_err = err_q;
`else
    logic [7:0] unused_tmo;
    assign unused_tmo = 8'(TMO_CYCLES);
    assign rsp_err    = 1'b0;
`endif

    // Next FIFO occupancy. It is used to register req_ready one cycle ahead.
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (!push && pop) begin
            count_nxt = count - 1'b1;
        end
    end

    // FIFO storage. It is not reset because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req_addr;
        end
    end

    // FIFO pointers, occupancy and the registered req_ready (!full)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            req_ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count     <= count_nxt;
            req_ready <= (count_nxt != FULL_CNT);
        end
    end

    // Bus FSM with registered strobes and the response holding register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr      <= 8'h00;
            as        <= 1'b0;
            rw        <= 1'b0;
            ds        <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
`ifdef QUIZ_RD_TIMEOUT_EN
            tmo_cnt   <= 8'h00;
            err_q     <= 1'b0;
`endif
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        addr  <= mem[rd_ptr];
                        as    <= 1'b1;
                        rw    <= 1'b1;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    ds    <= 1'b1;
                    state <= STROBE;
`ifdef QUIZ_RD_TIMEOUT_EN
                    tmo_cnt <= 8'h00;
`endif
                end
                STROBE: begin
                    if (da) begin
                        rsp_data  <= data;
                        rsp_valid <= 1'b1;
                        as        <= 1'b0;
                        rw        <= 1'b0;
                        ds        <= 1'b0;
                        state     <= RELEASE;
`ifdef QUIZ_RD_TIMEOUT_EN
                        err_q     <= 1'b0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // This edge is the TMO_CYCLES-th one with ds high, so the read is aborted
                        rsp_data  <= 8'h00;
                        err_q     <= 1'b1;
                        rsp_valid <= 1'b1;
                        as        <= 1'b0;
                        rw        <= 1'b0;
                        ds        <= 1'b0;
                        state     <= RELEASE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                RELEASE: begin
                    // The manager must drop da before another cycle may begin
                    if (!da) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
